// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: IDLE/REQ/DONE handshake with lane steering and timeout
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses complete at once with misalign_err)
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_misalign_err,
   output logic        o_timeout_err,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wstrb,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ready
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Encodings without a defined size (and LBU/LHU codes on stores) fall back to word access.
   function automatic logic [1:0] f_size(input logic we, input logic [2:0] f3);
      if (f3 == 3'b000 || (!we && f3 == 3'b100)) return SZ_B;
      if (f3 == 3'b001 || (!we && f3 == 3'b101)) return SZ_H;
      return SZ_W;
   endfunction

   state_t      r_state, w_next;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [7:0]  r_cnt;
   logic        r_terr;

   logic [1:0]  w_size;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load, w_st_data;
   logic [3:0]  w_st_strb;
   logic        w_trap, w_req, w_last;

`ifdef MISALIGN_TRAP_EN
   logic       r_merr;
   logic [1:0] w_in_size;

   assign w_in_size = f_size(i_we, i_funct3);
   assign w_trap    = (w_in_size == SZ_H && i_addr[0]) ||
                      (w_in_size == SZ_W && i_addr[1:0] != 2'b00);
   assign o_misalign_err = (r_state == S_DONE) && r_merr;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_merr <= 1'b0;
      else if (r_state == S_IDLE && i_start)
         r_merr <= w_trap;
   end
`else
   assign w_trap         = 1'b0;
   assign o_misalign_err = 1'b0;
`endif

   assign w_size = f_size(r_we, r_funct3);
   assign w_byte = i_mem_rdata[{r_addr[1:0], 3'b000} +: 8];
   assign w_half = i_mem_rdata[{r_addr[1], 4'b0000} +: 16];
   assign w_req  = (r_state == S_REQ);
   assign w_last = (r_cnt == LP_LAST);

   always_comb begin
      w_load = i_mem_rdata;
      case (w_size)
         SZ_B:    w_load = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
         SZ_H:    w_load = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
         default: w_load = i_mem_rdata;
      endcase
   end

   always_comb begin
      w_st_strb = 4'b1111;
      w_st_data = r_wdata;
      case (w_size)
         SZ_B: begin
            w_st_strb = 4'b0001 << r_addr[1:0];
            w_st_data = {4{r_wdata[7:0]}};
         end
         SZ_H: begin
            w_st_strb = r_addr[1] ? 4'b1100 : 4'b0011;
            w_st_data = {2{r_wdata[15:0]}};
         end
         default: begin
            w_st_strb = 4'b1111;
            w_st_data = r_wdata;
         end
      endcase
   end

   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = (r_state == S_DONE);
   assign o_timeout_err = (r_state == S_DONE) && r_terr;
   assign o_mem_req     = w_req;
   assign o_mem_we      = w_req && r_we;
   assign o_mem_addr    = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
   assign o_mem_wdata   = w_req ? w_st_data : 32'd0;
   assign o_mem_wstrb   = (w_req && r_we) ? w_st_strb : 4'b0000;
   assign o_rdata       = r_rdata;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = w_trap ? S_DONE : S_REQ;
         S_REQ:   if (i_mem_ready || w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Completion is checked before the timeout, so a ready on the last allowed cycle wins.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_rdata  <= 32'd0;
         r_cnt    <= 8'd0;
         r_terr   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_we     <= i_we;
                  r_funct3 <= i_funct3;
                  r_addr   <= i_addr;
                  r_wdata  <= i_wdata;
                  r_cnt    <= 8'd0;
                  r_terr   <= 1'b0;
               end
            end
            S_REQ: begin
               if (i_mem_ready) begin
                  if (!r_we) r_rdata <= w_load;
               end else if (w_last) begin
                  r_terr <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and random checks of load_store_unit against a behavioural model
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst, start, we, mem_ready;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, mem_rdata;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic        busy, done, misalign_err, timeout_err, mem_req, mem_we;
   logic [3:0]  mem_wstrb;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_rdata = 32'd0;

   load_store_unit #(.TIMEOUT(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_we(we), .i_funct3(funct3),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_busy(busy), .o_done(done),
      .o_misalign_err(misalign_err), .o_timeout_err(timeout_err), .o_mem_req(mem_req),
      .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * (a % 4))) % 256;
      h = (w >> (16 * ((a / 2) % 2))) % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? (b + 32'hFFFFFF00) : b;
         3'd1:    return (h >= 32768) ? (h + 32'hFFFF0000) : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'd0:    return 32'd1 << (a % 4);
         3'd1:    return ((a % 4) >= 2) ? 32'd12 : 32'd3;
         default: return 32'd15;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'd0:    return (w % 256) * 32'h01010101;
         3'd1:    return (w % 65536) * 32'h00010001;
         default: return w;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access; memory answers after lat wait cycles. Start is toggled randomly while busy.
   task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw, input int lat);
      start = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
      tick();
      start = 1'b0 | 1'($urandom_range(0, 1));
      addr  = $urandom; wdata = $urandom; we = 1'($urandom_range(0, 1));
      chk("req_busy", busy, 1);
      chk("req_mem_req", mem_req, 1);
      chk("req_mem_we", mem_we, w);
      chk("req_mem_addr", mem_addr, a - (a % 4));
      chk("req_wstrb", mem_wstrb, w ? m_strb(f3, a) : 32'd0);
      if (w) chk("req_wdata", mem_wdata, m_wdata(f3, wd));
      for (int i = 0; i < lat; i++) begin
         tick();
         chk("hold_mem_req", mem_req, 1);
         chk("hold_mem_addr", mem_addr, a - (a % 4));
      end
      start = 1'b0; mem_ready = 1'b1; mem_rdata = rw;
      tick();
      mem_ready = 1'b0; mem_rdata = $urandom;
      if (!w) exp_rdata = m_load(f3, a, rw);
      chk("done_pulse", done, 1);
      chk("done_timeout_err", timeout_err, 0);
      chk("done_misalign_err", misalign_err, 0);
      chk("done_mem_req", mem_req, 0);
      chk("done_rdata", rdata, exp_rdata);
      tick();
      chk("after_done", done, 0);
      chk("after_busy", busy, 0);
      chk("after_rdata", rdata, exp_rdata);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_errs"}, {misalign_err, timeout_err}, 0);
      chk({tag, "_req_we"}, {mem_req, mem_we}, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_wstrb"}, mem_wstrb, 0);
      chk({tag, "_rdata"}, rdata, 0);
   endtask

   initial begin
      int cnt;
      rst = 1'b1; start = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h100;
      wdata = 32'hFFFFFFFF; mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b0; start = 1'b0; mem_ready = 1'b0;
      tick();

      // SW, latency 2 cycles from start to done
      access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      // LB / LBU from top byte lane
      access(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FFFFFF, 1);
      chk("lb_203", rdata, 32'hFFFFFF80);
      access(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FFFFFF, 2);
      chk("lbu_203", rdata, 32'h00000080);
      access(1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0, 0);
      // Misaligned word: low bits ignored without the trap
      access(1'b0, 3'd2, 32'h101, 32'h0, 32'hCAFEF00D, 0);
      chk("lw_101", rdata, 32'hCAFEF00D);
      // Ready on the last allowed cycle completes normally
      access(1'b0, 3'd5, 32'h3E, 32'h0, 32'h9876ABCD, 15);
      chk("lhu_edge", rdata, 32'h00009876);

      // Timeout: mem_req for exactly 16 cycles, then done with timeout_err and rdata untouched
      start = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h400;
      tick();
      start = 1'b0;
      cnt = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!mem_req) break;
         cnt++;
      end
      chk("timeout_req_cycles", cnt, 16);
      chk("timeout_done", done, 1);
      chk("timeout_err", timeout_err, 1);
      chk("timeout_rdata", rdata, exp_rdata);
      tick();
      chk("timeout_idle", busy, 0);

      for (int k = 0; k < 40; k++)
         access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                $urandom, $urandom, $urandom_range(0, 5));

      // Reset during REQ with start and ready high aborts without a done pulse
      start = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h500; wdata = 32'h12345678;
      tick();
      rst = 1'b1; start = 1'b1; mem_ready = 1'b1;
      tick();
      chk_all_zero("rst_mid");
      rst = 1'b0; start = 1'b0; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_no_done", {done, busy}, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles held in REQ without mem_ready before abort; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request from control in MEMORY state; sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  access size/sign per RV32I load/store encoding.
REQ-007 addr  input  32  byte address (ALU result).
REQ-008 wdata  input  32  store data (rs2), low bits significant.
REQ-009 rdata  output  32  extended load result; valid while done=1 and held until next load completes.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 misalign_err  output  1  pulses with done when access was misaligned (macro-gated).
REQ-013 timeout_err  output  1  pulses with done when access aborted on timeout.
REQ-014 mem_req, mem_we  output  1 each  memory request and write-enable.
REQ-015 mem_addr  output  32  {addr[31:2],2'b00}.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_wstrb  output  4  byte-lane enables; 4'b0000 on loads.
REQ-018 mem_rdata  input  32  memory read word; mem_ready  input  1  memory accepts/completes request.

Function
REQ-019 FSM states IDLE, REQ, DONE; start in IDLE latches we, funct3, addr, wdata and moves to REQ next edge.
REQ-020 start while busy SHALL be ignored; no queuing.
REQ-021 In REQ: mem_req=1, mem_we=latched we, mem_addr/wdata/wstrb driven from latched values, stable until mem_ready.
REQ-022 Edge with mem_req&&mem_ready: capture extended load data into rdata register, go DONE; minimum start-to-done latency 2 cycles.
REQ-023 DONE lasts exactly one cycle: done=1, then IDLE.
REQ-024 Timeout counter clears on entry to REQ, increments each REQ cycle without mem_ready; on reaching TIMEOUT, drop mem_req, go DONE with timeout_err=1, rdata unchanged.
REQ-025 mem_ready in the same cycle the count reaches TIMEOUT: completion wins, no timeout_err.
REQ-026 Store lanes: SB wstrb=1<<addr[1:0], wdata byte replicated x4; SH wstrb=addr[1]?1100:0011, half replicated x2; SW wstrb=1111.
REQ-027 Load extract: byte = mem_rdata[8*addr[1:0]+:8], half = mem_rdata[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-028 Unsupported funct3 (011, 110, 111; 100/101 on stores) SHALL be treated as word access.
REQ-029 Stores leave rdata unchanged.

Reset
REQ-030 rst SHALL dominate start and mem_ready; next edge: state IDLE, counter 0, rdata 0.
REQ-031 All outputs 0 after reset: busy, done, errors, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, rdata.
REQ-032 rst during REQ drops mem_req on the next edge; no done pulse for the aborted access.

Configuration
REQ-033 MISALIGN_TRAP_EN defined: misaligned access (half with addr[0]=1, word with addr[1:0]!=0) skips REQ, goes IDLE->DONE with misalign_err=1, no mem_req, rdata unchanged.
REQ-034 MISALIGN_TRAP_EN undefined: misalign_err tied 0; low address bits ignored for the misaligned size (half uses addr[1], word uses lane 0).

Verification
REQ-035 SW addr=0x100 wdata=0xDEADBEEF, mem_ready=1 -> mem_wstrb=1111, mem_addr=0x100, done 2 cycles after start.
REQ-036 LB addr=0x203, mem_rdata=0x80FFFFFF -> rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr=0x102 wdata=0x1234 -> wstrb=1100, mem_wdata=0x12341234.
REQ-038 mem_ready held 0, TIMEOUT=16 -> mem_req high 16 cycles, then done with timeout_err=1.
REQ-039 LW addr=0x101 with MISALIGN_TRAP_EN -> no mem_req, done+misalign_err next cycle; without -> word read from 0x100.
REQ-040 rst asserted mid-REQ with start high -> IDLE, all outputs 0, no done pulse.
